// File: rtl/down_counter.sv
// down_counter: loadable down-counter / interval timer.
// Load a start value, start it, and it decrements on enable while running.
// The edge that takes count from 1 to 0 also raises a one-cycle done pulse
// and the sticky expired flag, so no extra cycle is spent idling at zero.
// Optional feature macro: DOWN_COUNTER_AUTO_RELOAD_EN. When it is defined,
// the terminal decrement reloads the last loaded value and keeps running.
module down_counter #(
  parameter int COUNT_WIDTH = 16,
  parameter int IDATA_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   enable,
  input  logic [IDATA_WIDTH-1:0] data_in,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   expired
);

  if (IDATA_WIDTH != COUNT_WIDTH) begin : g_width_check
    $error("down_counter: IDATA_WIDTH must equal COUNT_WIDTH");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     done_q, done_d;
  logic                     expired_q, expired_d;
  logic [COUNT_WIDTH-1:0]   reload_val;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [COUNT_WIDTH-1:0]   reload_q, reload_d;

  // Reload value tracks every load; a zero reload means one-shot behaviour.
  always_comb begin
    reload_d = reload_q;
    if (load) begin
      reload_d = COUNT_WIDTH'(data_in);
    end
  end

  // Reload register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end

  assign reload_val = reload_q;
`else
  assign reload_val = CNT_ZERO;
`endif

  // Next-state decode; priority is load > stop > start > enable.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    done_d    = 1'b0;
    expired_d = expired_q;
    if (load) begin
      count_d   = COUNT_WIDTH'(data_in);
      state_d   = ST_IDLE;
      expired_d = 1'b0;
    end else if (stop) begin
      // Aborting a run holds the count and leaves expired alone.
      if (state_q == ST_RUN) begin
        state_d = ST_IDLE;
      end
    end else if (start && (state_q == ST_IDLE)) begin
      if (count_q != CNT_ZERO) begin
        state_d   = ST_RUN;
        expired_d = 1'b0;
      end else begin
        // Zero-length timer: expire immediately without entering RUN.
        done_d    = 1'b1;
        expired_d = 1'b1;
      end
    end else if ((state_q == ST_RUN) && enable) begin
      if (count_q > CNT_ONE) begin
        count_d = count_q - CNT_ONE;
      end else if (count_q == CNT_ONE) begin
        done_d    = 1'b1;
        expired_d = 1'b1;
        if (reload_val != CNT_ZERO) begin
          count_d = reload_val;
        end else begin
          count_d = CNT_ZERO;
          state_d = ST_IDLE;
        end
      end else begin
        // Never reached in normal use; never wrap below zero.
        state_d = ST_IDLE;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: scoreboard bench for down_counter.
// Each step drives one cycle of inputs and pushes the expected outputs;
// after the clock edge the entry is popped and compared.
module tb_down_counter;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, load, start, stop, enable;
  logic [15:0] data_in;
  logic [15:0] count;
  logic        busy, done, expired;

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic        bsy;
    logic        dn;
    logic        exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  down_counter #(.COUNT_WIDTH(16), .IDATA_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop),
    .enable(enable), .data_in(data_in), .count(count), .busy(busy),
    .done(done), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Drive one cycle, push expectation, then pop and compare after the edge.
  task automatic step(input string tag, input logic rs, input logic ld, input logic st,
                      input logic sp, input logic en, input logic [15:0] d,
                      input logic [15:0] e_cnt, input logic e_bsy, input logic e_dn,
                      input logic e_exp);
    exp_t e;
    reset = rs; load = ld; start = st; stop = sp; enable = en; data_in = d;
    e.tag = tag; e.cnt = e_cnt; e.bsy = e_bsy; e.dn = e_dn; e.exp = e_exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_count"},   32'(count),   32'(e.cnt));
      check({e.tag, "_busy"},    32'(busy),    32'(e.bsy));
      check({e.tag, "_done"},    32'(done),    32'(e.dn));
      check({e.tag, "_expired"}, 32'(expired), 32'(e.exp));
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; enable = 1'b0; data_in = '0;
    @(posedge clk);
    #1;

    //        tag        rs ld st sp en data    cnt  bsy dn exp
    // Reset with load asserted: reset wins.
    step("rst0",      0, 1, 0, 0, 0, 16'hFF,  0,   0, 0, 0);
    step("rst1",      0, 1, 0, 0, 0, 16'hFF,  0,   0, 0, 0);

    // Basic countdown from 3 with continuous enable.
    step("ld3",       1, 1, 0, 0, 0, 3,       3,   0, 0, 0);
    step("st3",       1, 0, 1, 0, 1, 0,       3,   1, 0, 0);
    step("dec2",      1, 0, 0, 0, 1, 0,       2,   1, 0, 0);
    step("dec1",      1, 0, 0, 0, 1, 0,       1,   1, 0, 0);
    step("term3",     1, 0, 0, 0, 1, 0,       AR ? 16'd3 : 16'd0, AR, 1, 1);
    step("after3",    1, 0, 0, 1, 0, 0,       AR ? 16'd3 : 16'd0, 0, 0, 1);

    // Pause with enable low, then stop.
    step("ld5",       1, 1, 0, 0, 0, 5,       5,   0, 0, 0);
    step("st5",       1, 0, 1, 0, 1, 0,       5,   1, 0, 0);
    step("en1a",      1, 0, 0, 0, 1, 0,       4,   1, 0, 0);
    step("en0a",      1, 0, 0, 0, 0, 0,       4,   1, 0, 0);
    step("en0b",      1, 0, 0, 0, 0, 0,       4,   1, 0, 0);
    step("en1b",      1, 0, 0, 0, 1, 0,       3,   1, 0, 0);
    step("stop5",     1, 0, 0, 1, 1, 0,       3,   0, 0, 0);
    step("idle5",     1, 0, 0, 0, 1, 0,       3,   0, 0, 0);

    // Load beats start and stop; zero-length timer.
    step("ldall",     1, 1, 1, 1, 1, 9,       9,   0, 0, 0);
    step("ld0",       1, 1, 0, 0, 0, 0,       0,   0, 0, 0);
    step("zst",       1, 0, 1, 0, 0, 0,       0,   0, 1, 1);
    step("zpost",     1, 0, 0, 0, 0, 0,       0,   0, 0, 1);

    // Reset in the middle of a run.
    step("ld7",       1, 1, 0, 0, 0, 7,       7,   0, 0, 0);
    step("st7",       1, 0, 1, 0, 0, 0,       7,   1, 0, 0);
    step("dec6",      1, 0, 0, 0, 1, 0,       6,   1, 0, 0);
    step("rstrun",    0, 0, 0, 0, 1, 0,       0,   0, 0, 0);

    // Start while running is ignored.
    step("ld4",       1, 1, 0, 0, 0, 4,       4,   0, 0, 0);
    step("st4",       1, 0, 1, 0, 0, 0,       4,   1, 0, 0);
    step("rst4a",     1, 0, 1, 0, 1, 0,       3,   1, 0, 0);
    step("rst4b",     1, 0, 1, 0, 1, 0,       2,   1, 0, 0);
    step("dec4",      1, 0, 0, 0, 1, 0,       1,   1, 0, 0);
    step("term4",     1, 0, 0, 0, 1, 0,       AR ? 16'd4 : 16'd0, AR, 1, 1);
    step("after4",    1, 0, 0, 1, 1, 0,       AR ? 16'd4 : 16'd0, 0, 0, 1);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // Auto-reload: 2,1,2,1,... with done on every reload.
    step("arld",      1, 1, 0, 0, 0, 2,       2,   0, 0, 0);
    step("arst",      1, 0, 1, 0, 1, 0,       2,   1, 0, 0);
    step("ar1a",      1, 0, 0, 0, 1, 0,       1,   1, 0, 0);
    step("ar2a",      1, 0, 0, 0, 1, 0,       2,   1, 1, 1);
    step("ar1b",      1, 0, 0, 0, 1, 0,       1,   1, 0, 1);
    step("ar2b",      1, 0, 0, 0, 1, 0,       2,   1, 1, 1);
    step("arstop",    1, 0, 0, 1, 1, 0,       2,   0, 0, 1);
    step("arrestart", 1, 0, 1, 0, 0, 0,       2,   1, 0, 0);
    step("arstop2",   1, 0, 0, 1, 0, 0,       2,   0, 0, 0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
